// File: rtl/numarator_mod_if.sv
// Control and status bundle for the modulo-N up/down counter.
// The master side drives controls; the slave side is the counter itself.
interface numarator_mod_if #(
    parameter int LATIME = 6
);
    logic              pauza;
    logic              en_in;
    logic              sens;
    logic              incarcare;
    logic [LATIME-1:0] val_incarcare;
    logic [LATIME-1:0] valoare_bin;
    logic              carry_out;
    logic              borrow_out;
    logic              tc_out;

    modport master (
        output pauza, en_in, sens, incarcare, val_incarcare,
        input  valoare_bin, carry_out, borrow_out, tc_out
    );

    modport slave (
        input  pauza, en_in, sens, incarcare, val_incarcare,
        output valoare_bin, carry_out, borrow_out, tc_out
    );
endinterface

// File: rtl/numarator_mod.sv
// Modulo-MODUL up/down counter with clamped load, wrap or saturate mode,
// registered carry/borrow pulses and a combinational terminal-count for cascading.
module numarator_mod #(
    parameter int MODUL    = 60,
    parameter int LATIME   = 6,
    parameter int SATURARE = 0
) (
    input  logic            clk_out,
    input  logic            reset,
    numarator_mod_if.slave  bus
);
    localparam logic [LATIME-1:0] MAXV = LATIME'(MODUL - 1);

    logic [LATIME-1:0] valoare_q, valoare_d;
    logic              carry_q, carry_d;
    logic              borrow_q, borrow_d;
    logic              atTop, atZero;

    assign atTop  = (valoare_q == MAXV);
    assign atZero = (valoare_q == '0);

    // Priority: load, then pause/enable gating, then a single count step.
    always_comb begin
        valoare_d = valoare_q;
        carry_d   = 1'b0;
        borrow_d  = 1'b0;
        if (bus.incarcare) begin
            valoare_d = (bus.val_incarcare > MAXV) ? MAXV : bus.val_incarcare;
        end else if (!bus.pauza && bus.en_in) begin
            if (!bus.sens) begin
                if (!atTop) begin
                    valoare_d = valoare_q + LATIME'(1);
                end else if (SATURARE == 0) begin
                    valoare_d = '0;
                    carry_d   = 1'b1;
                end
            end else begin
                if (!atZero) begin
                    valoare_d = valoare_q - LATIME'(1);
                end else if (SATURARE == 0) begin
                    valoare_d = MAXV;
                    borrow_d  = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk_out or posedge reset) begin
        if (reset) begin
            valoare_q <= '0;
            carry_q   <= 1'b0;
            borrow_q  <= 1'b0;
        end else begin
            valoare_q <= valoare_d;
            carry_q   <= carry_d;
            borrow_q  <= borrow_d;
        end
    end

    // Same-cycle enable for the next stage; never asserted in saturate mode.
    assign bus.tc_out = (SATURARE == 0) && bus.en_in && !bus.pauza && !bus.incarcare
                        && (bus.sens ? atZero : atTop);

    assign bus.valoare_bin = valoare_q;
    assign bus.carry_out   = carry_q;
    assign bus.borrow_out  = borrow_q;
endmodule
